vram_term_ctrl: RTL and testbench

VRAM_TERM_CTRL -- requirements
Module: vram_term_ctrl

---
 rtl/vram_term_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_vram_term_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_term_ctrl.sv
// Character terminal front end: CPU character FIFO feeding VRAM writes, with clear-screen sweep.
// Define VRAM_SCROLL_EN for hardware scrolling via start_row; otherwise the cursor wraps to row 0.
module vram_term_ctrl #(
   parameter int COLS       = 40,
   parameter int ROWS       = 24,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk25,
   input  logic        rst,
   input  logic        tx_stb,
   input  logic [7:0]  tx_data,
   input  logic        clr_screen,
   output logic        tx_full,
   output logic        busy,
   output logic        vram_w_en,
   output logic [10:0] vram_w_addr,
   output logic [5:0]  vram_din,
   output logic [4:0]  start_row,
   output logic [10:0] cursor_addr
);
   localparam int         AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [5:0] LAST_COL = 6'(COLS - 1);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
   localparam logic [5:0] BLANK    = 6'd32;

   typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} state_e;
   state_e state_q, state_d;

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [AW:0]   count_q;
   logic          fifo_empty, do_pop, do_push, do_flush;

   logic [4:0]  cur_row_q, cur_row_d, start_row_q, start_row_d, sw_row_q, sw_row_d;
   logic [5:0]  cur_col_q, cur_col_d, sw_col_q, sw_col_d;
   logic        wr_en_d;
   logic [10:0] wr_addr_d;
   logic [5:0]  wr_din_d;

   logic [7:0] ch;
   logic       is_nl, is_cr, advance, scroll_hit, sweep_done;
   logic [4:0] next_row, cl_row;
   logic [5:0] cl_col;

   assign tx_full     = (count_q == (AW+1)'(FIFO_DEPTH));
   assign fifo_empty  = (count_q == '0);
   assign do_pop      = (state_q == IDLE) && !clr_screen && !fifo_empty;
   assign do_flush    = clr_screen && (state_q != CLEAR);
   assign do_push     = tx_stb && (!tx_full || do_pop) && !do_flush;

   assign busy        = (state_q != IDLE);
   assign start_row   = start_row_q;
   assign cursor_addr = {cur_row_q, cur_col_q};

   assign ch      = fifo_mem[rd_ptr_q];
   assign is_nl   = (ch == 8'h8D);
   assign is_cr   = (ch == 8'h9B) || (ch == 8'h7F);
   assign advance = do_pop && (is_nl || (!is_cr && cur_col_q == LAST_COL));

`ifdef VRAM_SCROLL_EN
   assign next_row   = cur_row_q + 5'd1;
   assign scroll_hit = (next_row == 5'(start_row_q + 5'(ROWS)));
`else
   assign next_row   = (cur_row_q == LAST_ROW) ? 5'd0 : cur_row_q + 5'd1;
   assign scroll_hit = 1'b0;
`endif

   // A clear request during the sweep restarts it at the origin in the same cycle.
   assign cl_row     = clr_screen ? 5'd0 : sw_row_q;
   assign cl_col     = clr_screen ? 6'd0 : sw_col_q;
   assign sweep_done = (cl_row == LAST_ROW) && (cl_col == LAST_COL);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk25) begin
      if (rst) begin
         state_q     <= IDLE;
         cur_row_q   <= '0;
         cur_col_q   <= '0;
         start_row_q <= '0;
         sw_row_q    <= '0;
         sw_col_q    <= '0;
         vram_w_en   <= 1'b0;
         vram_w_addr <= '0;
         vram_din    <= '0;
      end else begin
         state_q     <= state_d;
         cur_row_q   <= cur_row_d;
         cur_col_q   <= cur_col_d;
         start_row_q <= start_row_d;
         sw_row_q    <= sw_row_d;
         sw_col_q    <= sw_col_d;
         vram_w_en   <= wr_en_d;
         vram_w_addr <= wr_addr_d;
         vram_din    <= wr_din_d;
      end
   end

   always_ff @(posedge clk25) begin
      if (rst || do_flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage array has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk25) begin
      if (do_push) fifo_mem[wr_ptr_q] <= tx_data;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (clr_screen) state_d = CLEAR;
                  else if (advance && scroll_hit) state_d = SCROLL;
         SCROLL:  if (clr_screen) state_d = CLEAR;
                  else if (sw_col_q == LAST_COL) state_d = IDLE;
         CLEAR:   if (sweep_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      wr_en_d     = 1'b0;
      wr_addr_d   = vram_w_addr;
      wr_din_d    = vram_din;
      cur_row_d   = cur_row_q;
      cur_col_d   = cur_col_q;
      start_row_d = start_row_q;
      sw_row_d    = sw_row_q;
      sw_col_d    = sw_col_q;
      unique case (state_q)
         IDLE: begin
            sw_row_d = '0;
            sw_col_d = '0;
            if (do_pop) begin
               if (is_nl || is_cr) begin
                  cur_col_d = '0;
               end else begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = {cur_row_q, cur_col_q};
                  wr_din_d  = {~ch[6], ch[4:0]};
                  cur_col_d = cur_col_q + 6'd1;
               end
               if (advance) begin
                  cur_col_d = '0;
                  cur_row_d = next_row;
                  if (scroll_hit) start_row_d = start_row_q + 5'd1;
               end
            end
         end
         SCROLL: begin
            if (clr_screen) begin
               sw_col_d = '0;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = {cur_row_q, sw_col_q};
               wr_din_d  = BLANK;
               sw_col_d  = sw_col_q + 6'd1;
            end
         end
         CLEAR: begin
            wr_en_d   = 1'b1;
            wr_addr_d = {cl_row, cl_col};
            wr_din_d  = BLANK;
            if (cl_col == LAST_COL) begin
               sw_col_d = '0;
               sw_row_d = cl_row + 5'd1;
            end else begin
               sw_row_d = cl_row;
               sw_col_d = cl_col + 6'd1;
            end
            if (sweep_done) begin
               cur_row_d   = '0;
               cur_col_d   = '0;
               start_row_d = '0;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_vram_term_ctrl.sv
// Self-checking bench for vram_term_ctrl: vector table, directed clear/scroll/reset sequences,
// and random character streams scored against a screen-level model.
module tb_vram_term_ctrl;
   localparam int COLS = 40;
   localparam int ROWS = 24;

   logic        clk25 = 1'b0;
   logic        rst = 1'b1;
   logic        tx_stb = 1'b0;
   logic [7:0]  tx_data = '0;
   logic        clr_screen = 1'b0;
   logic        tx_full, busy, vram_w_en;
   logic [10:0] vram_w_addr, cursor_addr;
   logic [5:0]  vram_din;
   logic [4:0]  start_row;

   int checks = 0;
   int errors = 0;

   logic [16:0] wlog[$];
   logic [16:0] exp_q[$];

   vram_term_ctrl #(.COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(4)) dut (
      .clk25(clk25), .rst(rst), .tx_stb(tx_stb), .tx_data(tx_data), .clr_screen(clr_screen),
      .tx_full(tx_full), .busy(busy), .vram_w_en(vram_w_en), .vram_w_addr(vram_w_addr),
      .vram_din(vram_din), .start_row(start_row), .cursor_addr(cursor_addr)
   );

   always #20 clk25 = ~clk25;

   always @(negedge clk25) if (vram_w_en === 1'b1) wlog.push_back({vram_w_addr, vram_din});

   initial begin
      #(40 * 60000);
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   typedef struct {
      logic [7:0]  ch;
      logic        wr;
      logic [10:0] addr;
      logic [5:0]  din;
      logic [10:0] cur;
   } vec_t;
   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk25);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; tx_stb = 1'b0; clr_screen = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic drain(input int budget);
      int quiet = 0;
      logic done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (!busy && !vram_w_en) quiet++; else quiet = 0;
         if (quiet >= 8) begin done = 1'b1; break; end
      end
      check("drain_done", 32'(done), 32'd1);
   endtask

   function automatic logic [10:0] sweep_addr(input int i);
      return 11'((i / COLS) * 64 + (i % COLS));
   endfunction

   // Screen-level model: cursor/origin arithmetic straight from the character rules.
   int m_row, m_col, m_start;

   function automatic void m_advance();
`ifdef VRAM_SCROLL_EN
      m_row = (m_row + 1) % 32;
      if (m_row == (m_start + ROWS) % 32) begin
         m_start = (m_start + 1) % 32;
         for (int c = 0; c < COLS; c++) exp_q.push_back({5'(m_row), 6'(c), 6'd32});
      end
`else
      m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
`endif
   endfunction

   function automatic void m_char(input logic [7:0] c);
      if (c == 8'h8D) begin
         m_col = 0;
         m_advance();
      end else if (c == 8'h9B || c == 8'h7F) begin
         m_col = 0;
      end else begin
         exp_q.push_back({5'(m_row), 6'(m_col), ~c[6], c[4:0]});
         if (m_col == COLS - 1) begin
            m_col = 0;
            m_advance();
         end else begin
            m_col++;
         end
      end
   endfunction

   initial begin
      int n, busy_cnt, bad;
      logic [7:0] c;

      vecs[0]  = '{8'hC1, 1'b1, 11'h000, 6'h01, 11'h001};
      vecs[1]  = '{8'hC2, 1'b1, 11'h001, 6'h02, 11'h002};
      vecs[2]  = '{8'hA0, 1'b1, 11'h002, 6'h20, 11'h003};
      vecs[3]  = '{8'hB1, 1'b1, 11'h003, 6'h31, 11'h004};
      vecs[4]  = '{8'h9B, 1'b0, 11'h000, 6'h00, 11'h000};
      vecs[5]  = '{8'hDA, 1'b1, 11'h000, 6'h1A, 11'h001};
      vecs[6]  = '{8'h8D, 1'b0, 11'h000, 6'h00, 11'h040};
      vecs[7]  = '{8'h7F, 1'b0, 11'h000, 6'h00, 11'h040};
      vecs[8]  = '{8'h40, 1'b1, 11'h040, 6'h00, 11'h041};
      vecs[9]  = '{8'hFF, 1'b1, 11'h041, 6'h1F, 11'h042};
      vecs[10] = '{8'h0D, 1'b1, 11'h042, 6'h2D, 11'h043};

      // Reset state
      do_reset();
      check("rst_tx_full", 32'(tx_full), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_w_en", 32'(vram_w_en), 0);
      check("rst_w_addr", 32'(vram_w_addr), 0);
      check("rst_din", 32'(vram_din), 0);
      check("rst_start_row", 32'(start_row), 0);
      check("rst_cursor", 32'(cursor_addr), 0);

      // Single-character vectors: push, then the write is visible after the pop edge
      foreach (vecs[i]) begin
         tx_stb = 1'b1; tx_data = vecs[i].ch;
         tick();
         tx_stb = 1'b0;
         tick();
         check($sformatf("vec%0d_w_en", i), 32'(vram_w_en), 32'(vecs[i].wr));
         if (vecs[i].wr) begin
            check($sformatf("vec%0d_addr", i), 32'(vram_w_addr), 32'(vecs[i].addr));
            check($sformatf("vec%0d_din", i), 32'(vram_din), 32'(vecs[i].din));
         end
         check($sformatf("vec%0d_cursor", i), 32'(cursor_addr), 32'(vecs[i].cur));
      end

      // Full row of printable characters wraps the cursor to the next row
      do_reset(); wlog.delete();
      for (int i = 0; i < COLS; i++) begin
         tx_stb = 1'b1; tx_data = 8'(8'hC1 + (i % 26));
         tick();
      end
      tx_stb = 1'b0;
      drain(200);
      check("row_write_count", wlog.size(), COLS);
      check("row_last_addr", (wlog.size() > 0) ? 32'(wlog[$][16:6]) : 32'hFFFF, 32'h027);
      check("row_cursor", 32'(cursor_addr), 32'h040);

      // Newline run to the bottom row: scroll or wrap depending on build
      do_reset(); wlog.delete();
      busy_cnt = 0;
      for (int i = 0; i < ROWS; i++) begin
         tx_stb = 1'b1; tx_data = 8'h8D;
         tick();
         if (busy) busy_cnt++;
      end
      tx_stb = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (busy) busy_cnt++;
      end
`ifdef VRAM_SCROLL_EN
      check("scroll_start_row", 32'(start_row), 1);
      check("scroll_busy_cycles", busy_cnt, COLS);
      check("scroll_write_count", wlog.size(), COLS);
      bad = 0;
      for (int i = 0; i < COLS; i++)
         if (i >= wlog.size() || wlog[i] !== {11'(11'h600 + i), 6'd32}) bad++;
      check("scroll_row_blank", bad, 0);
      check("scroll_cursor", 32'(cursor_addr), 32'h600);
`else
      check("wrap_start_row", 32'(start_row), 0);
      check("wrap_busy_cycles", busy_cnt, 0);
      check("wrap_write_count", wlog.size(), 0);
      check("wrap_cursor", 32'(cursor_addr), 32'h000);
`endif

      // Pushes during CLEAR: four kept, two dropped, then written at cols 0..3
      do_reset(); wlog.delete();
      clr_screen = 1'b1; tick(); clr_screen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tx_stb = 1'b1; tx_data = 8'(8'hC1 + i);
         tick();
      end
      tx_stb = 1'b0;
      check("clear_tx_full", 32'(tx_full), 1);
      check("clear_busy", 32'(busy), 1);
      drain(2000);
      check("clear_write_count", wlog.size(), ROWS * COLS + 4);
      bad = 0;
      for (int i = 0; i < ROWS * COLS; i++)
         if (i >= wlog.size() || wlog[i] !== {sweep_addr(i), 6'd32}) bad++;
      check("clear_sweep_order", bad, 0);
      for (int i = 0; i < 4; i++)
         check($sformatf("clear_kept%0d", i),
               (ROWS * COLS + i < wlog.size()) ? 32'(wlog[ROWS * COLS + i]) : 32'h1FFFF,
               32'({11'(i), 6'(i + 1)}));
      check("clear_cursor", 32'(cursor_addr), 32'h004);
      check("clear_tx_full_after", 32'(tx_full), 0);

      // clr_screen during CLEAR restarts the sweep at the origin
      do_reset();
      clr_screen = 1'b1; tick(); clr_screen = 1'b0;
      n = 0;
      for (int i = 0; i < 2000 && n < 500; i++) begin
         tick();
         if (vram_w_en) n++;
      end
      check("restart_reached_500", n, 500);
      clr_screen = 1'b1; tick(); clr_screen = 1'b0;
      check("restart_first_addr", 32'({vram_w_en, vram_w_addr}), 32'({1'b1, 11'h000}));
      n = vram_w_en ? 1 : 0;
      bad = 0;
      for (int i = 0; i < 2000 && busy; i++) begin
         tick();
         if (vram_w_en) begin
            if (vram_w_addr !== sweep_addr(n)) bad++;
            n++;
         end
      end
      check("restart_write_count", n, ROWS * COLS);
      check("restart_sweep_order", bad, 0);
      check("restart_idle", 32'(busy), 0);

      // Reset while the CLEAR sweep is running
      do_reset();
      clr_screen = 1'b1; tick(); clr_screen = 1'b0;
      repeat (100) tick();
      rst = 1'b1; tick();
      check("rst_clear_w_en", 32'(vram_w_en), 0);
      check("rst_clear_busy", 32'(busy), 0);
      rst = 1'b0; wlog.delete();
      repeat (10) tick();
      check("rst_clear_no_writes", wlog.size(), 0);

`ifdef VRAM_SCROLL_EN
      // Reset while the scroll blanking is running
      do_reset();
      for (int i = 0; i < ROWS; i++) begin
         tx_stb = 1'b1; tx_data = 8'h8D;
         tick();
      end
      tx_stb = 1'b0;
      for (int i = 0; i < 10 && !busy; i++) tick();
      repeat (5) tick();
      check("rst_scroll_busy_before", 32'(busy), 1);
      rst = 1'b1; tick();
      check("rst_scroll_w_en", 32'(vram_w_en), 0);
      check("rst_scroll_start_row", 32'(start_row), 0);
      check("rst_scroll_cursor", 32'(cursor_addr), 0);
      rst = 1'b0; wlog.delete();
      repeat (10) tick();
      check("rst_scroll_no_writes", wlog.size(), 0);
`endif

      // Random character streams against the screen model
      for (int run = 0; run < 2; run++) begin
         do_reset(); wlog.delete(); exp_q.delete();
         m_row = 0; m_col = 0; m_start = 0;
         for (int k = 0; k < 700; k++) begin
            if (!tx_full && $urandom_range(0, 3) != 0) begin
               case ($urandom_range(0, 15))
                  0, 1:    c = 8'h8D;
                  2:       c = 8'h9B;
                  3:       c = 8'h7F;
                  default: c = 8'($urandom_range(0, 255));
               endcase
               tx_stb = 1'b1; tx_data = c;
               m_char(c);
            end
            tick();
            tx_stb = 1'b0;
         end
         drain(3000);
         check($sformatf("rand%0d_write_count", run), wlog.size(), exp_q.size());
         for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
            check($sformatf("rand%0d_write%0d", run, i), 32'(wlog[i]), 32'(exp_q[i]));
         check($sformatf("rand%0d_cursor", run), 32'(cursor_addr), 32'({5'(m_row), 6'(m_col)}));
         check($sformatf("rand%0d_start_row", run), 32'(start_row), 32'(5'(m_start)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
